// File: rtl/f_select_serial_tx_if.sv
// Word handshake between the frequency-select source and the serial transmitter.
// The transmitter's slave side is ready whenever its one-entry pending slot is free.
interface f_select_serial_tx_if #(
    parameter int WORD_WIDTH = 4
) ();
    logic                  i_valid;
    logic [WORD_WIDTH-1:0] i_data;
    logic                  o_ready;

    modport master (
        output i_valid,
        output i_data,
        input  o_ready
    );

    modport slave (
        input  i_valid,
        input  i_data,
        output o_ready
    );
endinterface

// File: rtl/f_select_serial_tx.sv
// Serialises 4-bit frequency-select words MSB first, framed by o_load_config,
// with a fixed low gap after each word so the CCD generator's receiver can latch.
module f_select_serial_tx #(
    parameter int WORD_WIDTH = 4,
    parameter int GAP_CYCLES = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_enable,
    f_select_serial_tx_if.slave  link,
    output logic                 o_f_select_serial,
    output logic                 o_load_config,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [CNT_WIDTH-1:0] o_words_sent
);
    localparam int BIT_CNT_W = $clog2(WORD_WIDTH);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(WORD_WIDTH - 1);
    localparam logic [3:0]           GAP_LAST = 4'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t                state_r, state_s;
    logic [WORD_WIDTH-1:0] shift_r, shift_s;
    logic [BIT_CNT_W-1:0]  bit_cnt_r, bit_cnt_s;
    logic [3:0]            gap_cnt_r, gap_cnt_s;
    logic [WORD_WIDTH-1:0] pend_r, pend_s;
    logic                  pend_vld_r, pend_vld_s;
    logic                  serial_r, serial_s;
    logic                  load_r, load_s;
    logic                  busy_r;
    logic                  done_r, done_s;
    logic [CNT_WIDTH-1:0]  words_r, words_s;
    logic                  ready_s;
    logic                  accept_s;

    // Ready is forced low while reset is held so every output reads 0 during reset.
    assign ready_s      = i_enable & ~pend_vld_r & i_rst_n;
    assign accept_s     = link.i_valid & ready_s;
    assign link.o_ready = ready_s;

    // Next-state and next-output logic; every register has a hold default first.
    always_comb begin
        state_s    = state_r;
        shift_s    = shift_r;
        bit_cnt_s  = bit_cnt_r;
        gap_cnt_s  = gap_cnt_r;
        pend_s     = pend_r;
        pend_vld_s = pend_vld_r;
        serial_s   = 1'b0;
        load_s     = 1'b0;
        done_s     = 1'b0;
        words_s    = words_r;

        if (!i_enable) begin
            // Abort: flush everything except the completed-word count.
            state_s    = IDLE;
            shift_s    = {WORD_WIDTH{1'b0}};
            bit_cnt_s  = {BIT_CNT_W{1'b0}};
            gap_cnt_s  = 4'd0;
            pend_s     = {WORD_WIDTH{1'b0}};
            pend_vld_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_s   = SHIFT;
                        shift_s   = link.i_data;
                        bit_cnt_s = {BIT_CNT_W{1'b0}};
                        serial_s  = link.i_data[WORD_WIDTH-1];
                        load_s    = 1'b1;
                    end else begin
                        state_s = IDLE;
                    end
                end
                SHIFT: begin
                    if (accept_s) begin
                        pend_s     = link.i_data;
                        pend_vld_s = 1'b1;
                    end else begin
                        pend_vld_s = pend_vld_r;
                    end
                    if (bit_cnt_r == BIT_LAST) begin
                        state_s   = GAP;
                        gap_cnt_s = GAP_LAST;
                    end else begin
                        bit_cnt_s = bit_cnt_r + {{(BIT_CNT_W-1){1'b0}}, 1'b1};
                        shift_s   = {shift_r[WORD_WIDTH-2:0], 1'b0};
                        serial_s  = shift_r[WORD_WIDTH-2];
                        load_s    = 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt_r == 4'd0) begin
                        done_s  = 1'b1;
                        words_s = words_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                        // A queued word (or one offered on this edge) starts with no bubble.
                        if (pend_vld_r) begin
                            state_s    = SHIFT;
                            shift_s    = pend_r;
                            pend_vld_s = 1'b0;
                            bit_cnt_s  = {BIT_CNT_W{1'b0}};
                            serial_s   = pend_r[WORD_WIDTH-1];
                            load_s     = 1'b1;
                        end else if (accept_s) begin
                            state_s   = SHIFT;
                            shift_s   = link.i_data;
                            bit_cnt_s = {BIT_CNT_W{1'b0}};
                            serial_s  = link.i_data[WORD_WIDTH-1];
                            load_s    = 1'b1;
                        end else begin
                            state_s = IDLE;
                        end
                    end else begin
                        gap_cnt_s = gap_cnt_r - 4'd1;
                        if (accept_s) begin
                            pend_s     = link.i_data;
                            pend_vld_s = 1'b1;
                        end else begin
                            pend_vld_s = pend_vld_r;
                        end
                    end
                end
                default: begin
                    state_s    = IDLE;
                    pend_vld_s = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r    <= IDLE;
            shift_r    <= {WORD_WIDTH{1'b0}};
            bit_cnt_r  <= {BIT_CNT_W{1'b0}};
            gap_cnt_r  <= 4'd0;
            pend_r     <= {WORD_WIDTH{1'b0}};
            pend_vld_r <= 1'b0;
            serial_r   <= 1'b0;
            load_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            words_r    <= {CNT_WIDTH{1'b0}};
        end else begin
            state_r    <= state_s;
            shift_r    <= shift_s;
            bit_cnt_r  <= bit_cnt_s;
            gap_cnt_r  <= gap_cnt_s;
            pend_r     <= pend_s;
            pend_vld_r <= pend_vld_s;
            serial_r   <= serial_s;
            load_r     <= load_s;
            busy_r     <= (state_s != IDLE);
            done_r     <= done_s;
            words_r    <= words_s;
        end
    end

    assign o_f_select_serial = serial_r;
    assign o_load_config     = load_r;
    assign o_busy            = busy_r;
    assign o_done            = done_r;
    assign o_words_sent      = words_r;
endmodule

// File: tb/tb_f_select_serial_tx.sv
// Directed bench for f_select_serial_tx: a 4-bit shift/latch receiver model
// follows the serial link; a second instance with a 4-bit counter covers wrap.
module tb_f_select_serial_tx;
    logic        clk;
    logic        rst_n;
    logic        en_a, en_b;
    logic        ser_a, load_a, busy_a, done_a;
    logic [15:0] words_a;
    logic        ser_b, load_b, busy_b, done_b;
    logic [3:0]  words_b;

    int checks   = 0;
    int failures = 0;

    f_select_serial_tx_if #(.WORD_WIDTH(4)) link_a ();
    f_select_serial_tx_if #(.WORD_WIDTH(4)) link_b ();

    f_select_serial_tx #(.WORD_WIDTH(4), .GAP_CYCLES(2), .CNT_WIDTH(16)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en_a), .link(link_a.slave),
        .o_f_select_serial(ser_a), .o_load_config(load_a), .o_busy(busy_a),
        .o_done(done_a), .o_words_sent(words_a)
    );

    f_select_serial_tx #(.WORD_WIDTH(4), .GAP_CYCLES(1), .CNT_WIDTH(4)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en_b), .link(link_b.slave),
        .o_f_select_serial(ser_b), .o_load_config(load_b), .o_busy(busy_b),
        .o_done(done_b), .o_words_sent(words_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Receiver model: shifts while load is high, latches on the first low cycle after 4 shifts.
    logic [3:0] rx_sr, rx_word;
    logic [2:0] rx_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sr <= 4'h0; rx_word <= 4'h0; rx_cnt <= 3'd0;
        end else if (!en_a) begin
            rx_cnt <= 3'd0;
        end else if (load_a) begin
            rx_sr  <= {rx_sr[2:0], ser_a};
            rx_cnt <= rx_cnt + 3'd1;
        end else if (rx_cnt == 3'd4) begin
            rx_word <= rx_sr;
            rx_cnt  <= 3'd0;
        end else begin
            rx_cnt <= 3'd0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    logic [13:0] exp_load, exp_ser;
    int dones;

    initial begin
        rst_n = 1'b0; en_a = 1'b1; en_b = 1'b0;
        link_a.i_valid = 1'b0; link_a.i_data = 4'h0;
        link_b.i_valid = 1'b0; link_b.i_data = 4'h0;
        #3;
        check_eq("rst_ready", {31'd0, link_a.o_ready}, 32'd0);
        check_eq("rst_load", {31'd0, load_a}, 32'd0);
        check_eq("rst_serial", {31'd0, ser_a}, 32'd0);
        check_eq("rst_busy", {31'd0, busy_a}, 32'd0);
        check_eq("rst_done", {31'd0, done_a}, 32'd0);
        check_eq("rst_words", {16'd0, words_a}, 32'd0);
        #5 rst_n = 1'b1;
        tick(); tick();

        // Single word 1011
        check_eq("idle_ready", {31'd0, link_a.o_ready}, 32'd1);
        link_a.i_valid = 1'b1; link_a.i_data = 4'b1011;
        tick();
        link_a.i_valid = 1'b0;
        exp_load = 14'b11110000000000;
        exp_ser  = 14'b10110000000000;
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("single_load_%0d", i), {31'd0, load_a}, {31'd0, exp_load[13-i]});
            check_eq($sformatf("single_ser_%0d", i), {31'd0, ser_a}, {31'd0, exp_ser[13-i]});
            check_eq($sformatf("single_done_%0d", i), {31'd0, done_a}, (i == 6) ? 32'd1 : 32'd0);
            check_eq($sformatf("single_busy_%0d", i), {31'd0, busy_a}, (i < 6) ? 32'd1 : 32'd0);
            tick();
        end
        check_eq("single_words", {16'd0, words_a}, 32'd1);
        check_eq("single_rx", {28'd0, rx_word}, 32'hB);

        // Back-to-back A then 5 through the pending slot
        link_a.i_valid = 1'b1; link_a.i_data = 4'hA;
        tick();
        exp_load = 14'b11110011110000;
        exp_ser  = 14'b10100001010000;
        for (int i = 0; i < 14; i++) begin
            check_eq($sformatf("b2b_load_%0d", i), {31'd0, load_a}, {31'd0, exp_load[13-i]});
            check_eq($sformatf("b2b_ser_%0d", i), {31'd0, ser_a}, {31'd0, exp_ser[13-i]});
            if (i == 0) link_a.i_data = 4'h5;
            if (i == 1) begin
                check_eq("b2b_ready_pending", {31'd0, link_a.o_ready}, 32'd0);
                link_a.i_valid = 1'b0;
            end
            if (i == 5) check_eq("b2b_rx_first", {28'd0, rx_word}, 32'hA);
            if (i == 6) begin
                check_eq("b2b_done_first", {31'd0, done_a}, 32'd1);
                check_eq("b2b_ready_drained", {31'd0, link_a.o_ready}, 32'd1);
            end
            if (i == 11) check_eq("b2b_rx_second", {28'd0, rx_word}, 32'h5);
            if (i == 12) begin
                check_eq("b2b_done_second", {31'd0, done_a}, 32'd1);
                check_eq("b2b_idle", {31'd0, busy_a}, 32'd0);
            end
            tick();
        end
        check_eq("b2b_words", {16'd0, words_a}, 32'd3);

        // Gap-end bypass: 6, then 9 offered on the final gap cycle
        link_a.i_valid = 1'b1; link_a.i_data = 4'h6;
        tick();
        link_a.i_valid = 1'b0;
        exp_load = 14'b11110011110000;
        exp_ser  = 14'b01100010010000;
        for (int i = 0; i < 13; i++) begin
            check_eq($sformatf("byp_load_%0d", i), {31'd0, load_a}, {31'd0, exp_load[13-i]});
            check_eq($sformatf("byp_ser_%0d", i), {31'd0, ser_a}, {31'd0, exp_ser[13-i]});
            if (i == 5) begin
                check_eq("byp_ready", {31'd0, link_a.o_ready}, 32'd1);
                link_a.i_valid = 1'b1; link_a.i_data = 4'h9;
            end
            if (i == 6) begin
                link_a.i_valid = 1'b0;
                check_eq("byp_done", {31'd0, done_a}, 32'd1);
                check_eq("byp_busy", {31'd0, busy_a}, 32'd1);
            end
            if (i == 11) check_eq("byp_rx", {28'd0, rx_word}, 32'h9);
            tick();
        end
        check_eq("byp_words", {16'd0, words_a}, 32'd5);

        // Abort during bit 1 of F with 7 pending
        link_a.i_valid = 1'b1; link_a.i_data = 4'hF;
        tick();
        link_a.i_data = 4'h7;
        tick();
        check_eq("abort_ready_pending", {31'd0, link_a.o_ready}, 32'd0);
        link_a.i_valid = 1'b0;
        tick();
        check_eq("abort_bit1", {31'd0, ser_a}, 32'd1);
        en_a = 1'b0;
        tick();
        check_eq("abort_load", {31'd0, load_a}, 32'd0);
        check_eq("abort_ser", {31'd0, ser_a}, 32'd0);
        check_eq("abort_busy", {31'd0, busy_a}, 32'd0);
        check_eq("abort_done", {31'd0, done_a}, 32'd0);
        check_eq("abort_ready", {31'd0, link_a.o_ready}, 32'd0);
        check_eq("abort_words", {16'd0, words_a}, 32'd5);
        tick();
        check_eq("abort_done_later", {31'd0, done_a}, 32'd0);
        en_a = 1'b1;
        #1;
        check_eq("reen_ready", {31'd0, link_a.o_ready}, 32'd1);
        tick();
        check_eq("reen_flushed", {31'd0, busy_a}, 32'd0);
        check_eq("abort_rx_kept", {28'd0, rx_word}, 32'h9);
        link_a.i_valid = 1'b1; link_a.i_data = 4'h3;
        tick();
        link_a.i_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check_eq("reen_rx", {28'd0, rx_word}, 32'h3);
        check_eq("reen_words", {16'd0, words_a}, 32'd6);

        // Asynchronous reset in the middle of the gap
        link_a.i_valid = 1'b1; link_a.i_data = 4'hC;
        tick();
        link_a.i_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_eq("arst_pre_busy", {31'd0, busy_a}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("arst_busy", {31'd0, busy_a}, 32'd0);
        check_eq("arst_load", {31'd0, load_a}, 32'd0);
        check_eq("arst_ser", {31'd0, ser_a}, 32'd0);
        check_eq("arst_ready", {31'd0, link_a.o_ready}, 32'd0);
        check_eq("arst_done", {31'd0, done_a}, 32'd0);
        check_eq("arst_words", {16'd0, words_a}, 32'd0);
        #2 rst_n = 1'b1;
        tick();

        // Counter wrap on the 4-bit instance, words streamed continuously
        en_b = 1'b1; link_b.i_valid = 1'b1; link_b.i_data = 4'h5;
        dones = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (done_b) begin
                dones++;
                if (dones == 15) check_eq("wrap_15", {28'd0, words_b}, 32'd15);
                if (dones == 16) begin
                    check_eq("wrap_0", {28'd0, words_b}, 32'd0);
                    break;
                end
            end
        end
        link_b.i_valid = 1'b0;
        check_eq("wrap_done_count", dones, 32'd16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
